// File: rtl/overlay_compositor.sv
// overlay_compositor: composites up to four keyed card video layers over the Apple II video stream
// Ports: clk_logic_i/reset_i clock and async active-high reset; card_enable_i gates the overlay path;
//   sw_wr_i/sw_addr_i/sw_data_i soft-switch and register writes, sw_data_o combinational readback;
//   screen_x_i/screen_y_i raster position, entering (0,0) commits the shadowed registers;
//   apple_*_i Apple pixel; layer_*_i packed layer pixels and flags, layer 0 in the LSBs;
//   mix_*_o/layer_sel_o composited pixel and its source (2-clock latency); frame_start_o commit pulse.
module overlay_compositor #(
  parameter int NUM_LAYERS = 2,
  parameter int COLOR_W = 4,
  parameter bit EXPAND_REPLICATE = 1'b0,
  parameter bit FORCE_OVERLAY = 1'b0
) (
  input  logic                             clk_logic_i,
  input  logic                             reset_i,
  input  logic                             card_enable_i,
  input  logic                             sw_wr_i,
  input  logic [3:0]                       sw_addr_i,
  input  logic [7:0]                       sw_data_i,
  output logic [7:0]                       sw_data_o,
  input  logic [9:0]                       screen_x_i,
  input  logic [9:0]                       screen_y_i,
  input  logic [7:0]                       apple_r_i,
  input  logic [7:0]                       apple_g_i,
  input  logic [7:0]                       apple_b_i,
  input  logic [NUM_LAYERS*COLOR_W-1:0]    layer_r_i,
  input  logic [NUM_LAYERS*COLOR_W-1:0]    layer_g_i,
  input  logic [NUM_LAYERS*COLOR_W-1:0]    layer_b_i,
  input  logic [NUM_LAYERS-1:0]            layer_transparent_i,
  input  logic [NUM_LAYERS-1:0]            layer_ext_video_i,
  output logic [7:0]                       mix_r_o,
  output logic [7:0]                       mix_g_o,
  output logic [7:0]                       mix_b_o,
  output logic [2:0]                       layer_sel_o,
  output logic                             frame_start_o
);
  localparam int LW = 4 * COLOR_W;
  logic r_apple_sw, r_overlay_sw, r_prev_zero, r_frame_start;
  logic [NUM_LAYERS-1:0] r_mask_p, r_mask_a, w_mask_n;
  logic [2*NUM_LAYERS-1:0] r_mode_p, r_mode_a, w_mode_n;
  logic [7:0] r_prio_p, r_prio_a, w_prio_n, r_frame_cnt;
  logic w_zero, w_commit;
  logic [LW-1:0] w_lr, w_lg, w_lb, r_s1_lr, r_s1_lg, r_s1_lb;
  logic [3:0] w_t, w_e, w_mask, w_hit, r_s1_hit;
  logic [7:0] w_mode, r_s1_prio, r_s1_ar, r_s1_ag, r_s1_ab;
  logic r_s1_en, r_s1_apple;
  logic [1:0] w_src;
  logic w_win;
  logic [2:0] w_sel, r_sel;
  logic [7:0] w_cr, w_cg, w_cb, r_mix_r, r_mix_g, r_mix_b;

  function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
    logic [7:0] e;
    for (int i = 0; i < 8; i++)
      e[7-i] = (EXPAND_REPLICATE || i < COLOR_W) ? c[COLOR_W-1-(i%COLOR_W)] : 1'b0;
    return e;
  endfunction

  assign w_zero = screen_x_i == '0 && screen_y_i == '0;
  assign w_commit = w_zero && !r_prev_zero;
  // a write landing in the commit cycle must reach the active copy too
  assign w_mask_n = (sw_wr_i && sw_addr_i == 4'h8) ? sw_data_i[NUM_LAYERS-1:0] : r_mask_p;
  assign w_mode_n = (sw_wr_i && sw_addr_i == 4'h9) ? sw_data_i[2*NUM_LAYERS-1:0] : r_mode_p;
  assign w_prio_n = (sw_wr_i && sw_addr_i == 4'hA) ? sw_data_i : r_prio_p;
  assign sw_data_o = sw_addr_i == 4'h8 ? 8'(r_mask_p) :
                     sw_addr_i == 4'h9 ? 8'(r_mode_p) :
                     sw_addr_i == 4'hA ? r_prio_p :
                     sw_addr_i == 4'hB ? r_frame_cnt : 8'h00;

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      r_apple_sw <= 1'b1;
      r_overlay_sw <= FORCE_OVERLAY;
      r_mask_p <= '1;
      r_mask_a <= '1;
      r_mode_p <= {NUM_LAYERS{2'b10}};
      r_mode_a <= {NUM_LAYERS{2'b10}};
      r_prio_p <= 8'hE4;
      r_prio_a <= 8'hE4;
      r_frame_cnt <= 8'h00;
      r_prev_zero <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      if (sw_wr_i && sw_addr_i == 4'h3) r_apple_sw <= 1'b0;
      if (sw_wr_i && sw_addr_i == 4'h4) r_apple_sw <= 1'b1;
      if (sw_wr_i && sw_addr_i == 4'h5) r_overlay_sw <= FORCE_OVERLAY;
      if (sw_wr_i && sw_addr_i == 4'h6) r_overlay_sw <= 1'b1;
      r_mask_p <= w_mask_n;
      r_mode_p <= w_mode_n;
      r_prio_p <= w_prio_n;
      r_prev_zero <= w_zero;
      r_frame_start <= w_commit;
      if (w_commit) begin
        r_mask_a <= w_mask_n;
        r_mode_a <= w_mode_n;
        r_prio_a <= w_prio_n;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // pad to four layers; absent layers carry a zero mask bit so they never hit
  assign w_lr = LW'(layer_r_i);
  assign w_lg = LW'(layer_g_i);
  assign w_lb = LW'(layer_b_i);
  assign w_t = 4'(layer_transparent_i);
  assign w_e = 4'(layer_ext_video_i);
  assign w_mask = 4'(r_mask_a);
  assign w_mode = 8'(r_mode_a);

  for (genvar g = 0; g < 4; g++) begin : g_hit
    logic [1:0] w_m;
    logic w_nz;
    assign w_m = w_mode[2*g +: 2];
    assign w_nz = |{w_lr[g*COLOR_W +: COLOR_W], w_lg[g*COLOR_W +: COLOR_W], w_lb[g*COLOR_W +: COLOR_W]};
    assign w_hit[g] = w_mask[g] && (w_m == 2'b11 ||
                      ((w_m == 2'b01 || (w_m == 2'b10 && w_e[g])) ? !w_t[g] : w_nz));
  end

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      r_s1_hit <= '0;
      r_s1_en <= 1'b0;
      r_s1_apple <= 1'b0;
      r_s1_prio <= 8'h00;
      r_s1_lr <= '0;
      r_s1_lg <= '0;
      r_s1_lb <= '0;
      r_s1_ar <= 8'h00;
      r_s1_ag <= 8'h00;
      r_s1_ab <= 8'h00;
    end else begin
      r_s1_hit <= w_hit;
      r_s1_en <= r_overlay_sw && card_enable_i;
      r_s1_apple <= r_apple_sw;
      r_s1_prio <= r_prio_a;
      r_s1_lr <= w_lr;
      r_s1_lg <= w_lg;
      r_s1_lb <= w_lb;
      r_s1_ar <= apple_r_i;
      r_s1_ag <= apple_g_i;
      r_s1_ab <= apple_b_i;
    end
  end

  // walk slots from lowest priority up so the highest-priority hit is the last one kept
  always_comb begin
    w_src = 2'd0;
    w_win = 1'b0;
    for (int s = 3; s >= 0; s--)
      if (r_s1_hit[r_s1_prio[2*s +: 2]]) begin
        w_src = r_s1_prio[2*s +: 2];
        w_win = 1'b1;
      end
    w_sel = (r_s1_en && w_win) ? {1'b0, w_src} : r_s1_apple ? 3'd4 : 3'd5;
    w_cr = expand(r_s1_lr[int'(w_src)*COLOR_W +: COLOR_W]);
    w_cg = expand(r_s1_lg[int'(w_src)*COLOR_W +: COLOR_W]);
    w_cb = expand(r_s1_lb[int'(w_src)*COLOR_W +: COLOR_W]);
  end

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      r_mix_r <= 8'h00;
      r_mix_g <= 8'h00;
      r_mix_b <= 8'h00;
      r_sel <= 3'd0;
    end else begin
      r_mix_r <= w_sel[2] ? (w_sel[0] ? 8'h00 : r_s1_ar) : w_cr;
      r_mix_g <= w_sel[2] ? (w_sel[0] ? 8'h00 : r_s1_ag) : w_cg;
      r_mix_b <= w_sel[2] ? (w_sel[0] ? 8'h00 : r_s1_ab) : w_cb;
      r_sel <= w_sel;
    end
  end

  assign mix_r_o = r_mix_r;
  assign mix_g_o = r_mix_g;
  assign mix_b_o = r_mix_b;
  assign layer_sel_o = r_sel;
  assign frame_start_o = r_frame_start;
endmodule
